// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: decode request, forwarding taps and ALU-facing result.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_IDX_W = 3,
    parameter int unsigned IMM_W     = 6
);
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_rs1_idx;
    logic [REG_IDX_W-1:0] in_rs2_idx;
    logic [DATA_W-1:0]    in_rs1_data;
    logic [DATA_W-1:0]    in_rs2_data;
    logic [IMM_W-1:0]     in_imm;
    logic                 in_use_imm;
    logic                 in_imm_signed;
    logic [1:0]           in_alu_op;
    logic [REG_IDX_W-1:0] in_rd;
    logic                 in_rd_we;

    logic                 fwd_exmem_we;
    logic [REG_IDX_W-1:0] fwd_exmem_rd;
    logic [DATA_W-1:0]    fwd_exmem_data;
    logic                 fwd_memwb_we;
    logic [REG_IDX_W-1:0] fwd_memwb_rd;
    logic [DATA_W-1:0]    fwd_memwb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic [1:0]           ALUop;
    logic [REG_IDX_W-1:0] out_rd;
    logic                 out_rd_we;

    // Upstream/environment side
    modport master (
        output in_valid, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_imm_signed, in_alu_op, in_rd, in_rd_we,
               fwd_exmem_we, fwd_exmem_rd, fwd_exmem_data,
               fwd_memwb_we, fwd_memwb_rd, fwd_memwb_data, out_ready,
        input  in_ready, out_valid, A, B, ALUop, out_rd, out_rd_we
    );

    // Pipeline-register side
    modport slave (
        input  in_valid, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_imm_signed, in_alu_op, in_rd, in_rd_we,
               fwd_exmem_we, fwd_exmem_rd, fwd_exmem_data,
               fwd_memwb_we, fwd_memwb_rd, fwd_memwb_data, out_ready,
        output in_ready, out_valid, A, B, ALUop, out_rd, out_rd_we
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry holding stage with immediate extension
// and EX/MEM, MEM/WB operand forwarding onto the ALU inputs.
module id_ex_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_IDX_W = 3,
    parameter int unsigned IMM_W     = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    id_ex_stage_if.slave bus
);
    localparam int unsigned EXT_W = DATA_W - IMM_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state_q,    state_d;
    logic [REG_IDX_W-1:0] rs1_idx_q,  rs1_idx_d;
    logic [REG_IDX_W-1:0] rs2_idx_q,  rs2_idx_d;
    logic [DATA_W-1:0]    rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]    b_data_q,   b_data_d;
    logic                 b_is_imm_q, b_is_imm_d;
    logic [1:0]           alu_op_q,   alu_op_d;
    logic [REG_IDX_W-1:0] rd_q,       rd_d;
    logic                 rd_we_q,    rd_we_d;

    logic                 accept;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    a_fwd;
    logic [DATA_W-1:0]    b_fwd;

    assign bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == FULL);

    // Immediate extension selected per instruction
    always_comb begin
        imm_ext = {{EXT_W{1'b0}}, bus.in_imm};
        if (bus.in_imm_signed) begin
            imm_ext = {{EXT_W{bus.in_imm[IMM_W-1]}}, bus.in_imm};
        end
    end

    // Next-state and capture: flush wins, then accept, then consume
    always_comb begin
        state_d    = state_q;
        rs1_idx_d  = rs1_idx_q;
        rs2_idx_d  = rs2_idx_q;
        rs1_data_d = rs1_data_q;
        b_data_d   = b_data_q;
        b_is_imm_d = b_is_imm_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d    = FULL;
            rs1_idx_d  = bus.in_rs1_idx;
            rs2_idx_d  = bus.in_rs2_idx;
            rs1_data_d = bus.in_rs1_data;
            b_data_d   = bus.in_use_imm ? imm_ext : bus.in_rs2_data;
            b_is_imm_d = bus.in_use_imm;
            alu_op_d   = bus.in_alu_op;
            rd_d       = bus.in_rd;
            rd_we_d    = bus.in_rd_we;
        end else if (bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    // State and held-instruction registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            rs1_idx_q  <= '0;
            rs2_idx_q  <= '0;
            rs1_data_q <= '0;
            b_data_q   <= '0;
            b_is_imm_q <= 1'b0;
            alu_op_q   <= 2'b00;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs1_idx_q  <= rs1_idx_d;
            rs2_idx_q  <= rs2_idx_d;
            rs1_data_q <= rs1_data_d;
            b_data_q   <= b_data_d;
            b_is_imm_q <= b_is_imm_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
        end
    end

    // Operand forwarding, EX/MEM before MEM/WB; R0 never forwarded
    always_comb begin
        a_fwd = rs1_data_q;
        if ((rs1_idx_q != '0) && bus.fwd_exmem_we && (bus.fwd_exmem_rd == rs1_idx_q)) begin
            a_fwd = bus.fwd_exmem_data;
        end else if ((rs1_idx_q != '0) && bus.fwd_memwb_we && (bus.fwd_memwb_rd == rs1_idx_q)) begin
            a_fwd = bus.fwd_memwb_data;
        end
        b_fwd = b_data_q;
        if (!b_is_imm_q) begin
            if ((rs2_idx_q != '0) && bus.fwd_exmem_we && (bus.fwd_exmem_rd == rs2_idx_q)) begin
                b_fwd = bus.fwd_exmem_data;
            end else if ((rs2_idx_q != '0) && bus.fwd_memwb_we && (bus.fwd_memwb_rd == rs2_idx_q)) begin
                b_fwd = bus.fwd_memwb_data;
            end
        end
    end

    // Outputs forced to zero whenever no instruction is held
    always_comb begin
        bus.A         = '0;
        bus.B         = '0;
        bus.ALUop     = 2'b00;
        bus.out_rd    = '0;
        bus.out_rd_we = 1'b0;
        if (state_q == FULL) begin
            bus.A         = a_fwd;
            bus.B         = b_fwd;
            bus.ALUop     = alu_op_q;
            bus.out_rd    = rd_q;
            bus.out_rd_we = rd_we_q;
        end
    end
endmodule
